udma_eth_frame_cfg_seq: RTL and testbench



---
 rtl/udma_eth_frame_cfg_seq.sv | 203 ++++++++++++++++++++
 tb/tb_udma_eth_frame_cfg_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_eth_frame_cfg_seq.sv
// Command sequencer for the uDMA Ethernet-frame RX/TX channels: round-robin arbitration,
// SADDR/SIZE/CFG register writes, then CFG status polling. Optional poll timeout: ETH_FRAME_SEQ_TIMEOUT_EN.
module udma_eth_frame_cfg_seq #(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned POLL_GAP       = 4,
  parameter int unsigned MAX_POLLS      = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_req_i,
  input  logic [L2_AWIDTH_NOAL-1:0] rx_addr_i,
  input  logic [TRANS_SIZE-1:0]     rx_size_i,
  input  logic                      rx_cont_i,
  output logic                      rx_ack_o,
  output logic                      rx_done_o,
  input  logic                      tx_req_i,
  input  logic [L2_AWIDTH_NOAL-1:0] tx_addr_i,
  input  logic [TRANS_SIZE-1:0]     tx_size_i,
  input  logic                      tx_cont_i,
  output logic                      tx_ack_o,
  output logic                      tx_done_o,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    IDLE, W_SADDR, W_SIZE, W_CFG, P_WAIT, P_RD,
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
    CLR,
`endif
    DONE
  } state_t;

  state_t                    state_q, state_n;
  logic                      chan_q, chan_n;   // 1 = TX channel active
  logic                      last_q, last_n;   // 1 = TX granted last
  logic [L2_AWIDTH_NOAL-1:0] addr_q, addr_n;
  logic [TRANS_SIZE-1:0]     size_q, size_n;
  logic                      cont_q, cont_n;
  logic [GW-1:0]             gap_q, gap_n;
  logic                      grant_tx;
  logic                      fire;

  logic        rx_ack_n, tx_ack_n, rx_done_n, tx_done_n, err_n, busy_n;
  logic        valid_n, rwn_n;
  logic [4:0]  reg_n;
  logic [31:0] data_n;

`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
  localparam int unsigned PW = $clog2(MAX_POLLS + 1);
  logic [PW-1:0] poll_q, poll_n;
`endif

  logic unused_rd;
  assign unused_rd = ^{cfg_data_i[31:5], cfg_data_i[3:0]};

  assign fire = cfg_valid_o & cfg_ready_i;

  always_comb begin
    state_n  = state_q;
    chan_n   = chan_q;
    last_n   = last_q;
    addr_n   = addr_q;
    size_n   = size_q;
    cont_n   = cont_q;
    gap_n    = gap_q;
    grant_tx = 1'b0;
    rx_ack_n = 1'b0;
    tx_ack_n = 1'b0;
    err_n    = 1'b0;
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
    poll_n   = poll_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_req_i || tx_req_i) begin
          grant_tx = tx_req_i && (!rx_req_i || !last_q);
          chan_n   = grant_tx;
          last_n   = grant_tx;
          addr_n   = grant_tx ? tx_addr_i : rx_addr_i;
          size_n   = grant_tx ? tx_size_i : rx_size_i;
          cont_n   = grant_tx ? tx_cont_i : rx_cont_i;
          rx_ack_n = !grant_tx;
          tx_ack_n = grant_tx;
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
          poll_n   = '0;
`endif
          state_n  = (size_n == '0) ? DONE : W_SADDR;
        end
      end
      W_SADDR: if (fire) state_n = W_SIZE;
      W_SIZE:  if (fire) state_n = W_CFG;
      W_CFG: begin
        if (fire) begin
          gap_n   = '0;
          state_n = cont_q ? DONE : P_WAIT;
        end
      end
      P_WAIT: begin
        if (gap_q == GW'(POLL_GAP - 1)) state_n = P_RD;
        else                            gap_n   = gap_q + 1'b1;
      end
      P_RD: begin
        if (fire) begin
          gap_n = '0;
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
          poll_n = poll_q + 1'b1;
          if (!cfg_data_i[4])                          state_n = DONE;
          else if (poll_q + 1'b1 == PW'(MAX_POLLS))    state_n = CLR;
          else                                         state_n = P_WAIT;
`else
          state_n = cfg_data_i[4] ? P_WAIT : DONE;
`endif
        end
      end
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
      CLR: begin
        if (fire) begin
          err_n   = 1'b1;
          state_n = DONE;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are a function of the next state so that every port is a plain register.
    valid_n   = 1'b0;
    rwn_n     = 1'b0;
    reg_n     = '0;
    data_n    = '0;
    rx_done_n = (state_n == DONE) && !chan_n;
    tx_done_n = (state_n == DONE) && chan_n;
    busy_n    = (state_n != IDLE);
    unique case (state_n)
      W_SADDR: begin valid_n = 1'b1; reg_n = {2'b00, chan_n, 2'd0}; data_n = 32'(addr_n); end
      W_SIZE:  begin valid_n = 1'b1; reg_n = {2'b00, chan_n, 2'd1}; data_n = 32'(size_n); end
      W_CFG:   begin valid_n = 1'b1; reg_n = {2'b00, chan_n, 2'd2}; data_n = {27'd0, 1'b1, 3'd0, cont_n}; end
      P_RD:    begin valid_n = 1'b1; rwn_n = 1'b1; reg_n = {2'b00, chan_n, 2'd2}; end
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
      CLR:     begin valid_n = 1'b1; reg_n = {2'b00, chan_n, 2'd2}; data_n = 32'h0000_0040; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      chan_q      <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      size_q      <= '0;
      cont_q      <= 1'b0;
      gap_q       <= '0;
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
      poll_q      <= '0;
`endif
      rx_ack_o    <= 1'b0;
      tx_ack_o    <= 1'b0;
      rx_done_o   <= 1'b0;
      tx_done_o   <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      cfg_valid_o <= 1'b0;
      cfg_rwn_o   <= 1'b0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
    end else begin
      state_q     <= state_n;
      chan_q      <= chan_n;
      last_q      <= last_n;
      addr_q      <= addr_n;
      size_q      <= size_n;
      cont_q      <= cont_n;
      gap_q       <= gap_n;
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
      poll_q      <= poll_n;
`endif
      rx_ack_o    <= rx_ack_n;
      tx_ack_o    <= tx_ack_n;
      rx_done_o   <= rx_done_n;
      tx_done_o   <= tx_done_n;
      err_o       <= err_n;
      busy_o      <= busy_n;
      cfg_valid_o <= valid_n;
      cfg_rwn_o   <= rwn_n;
      cfg_addr_o  <= reg_n;
      cfg_data_o  <= data_n;
    end
  end

endmodule

// File: tb/tb_udma_eth_frame_cfg_seq.sv
// Self-checking bench for udma_eth_frame_cfg_seq: vector table, hand sequences and random commands
// checked against a transaction-level model of the register programming sequence.
module tb_udma_eth_frame_cfg_seq;

  localparam int G    = 4;
  localparam int MAXP = 3;
`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_req_i = 1'b0, tx_req_i = 1'b0;
  logic [11:0] rx_addr_i = '0, tx_addr_i = '0;
  logic [15:0] rx_size_i = '0, tx_size_i = '0;
  logic        rx_cont_i = 1'b0, tx_cont_i = 1'b0;
  logic        rx_ack_o, rx_done_o, tx_ack_o, tx_done_o;
  logic [31:0] cfg_data_o;
  logic [4:0]  cfg_addr_o;
  logic        cfg_valid_o, cfg_rwn_o;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_i;
  logic        busy_o, err_o;

  udma_eth_frame_cfg_seq #(
    .L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .POLL_GAP(G), .MAX_POLLS(MAXP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_req_i(rx_req_i), .rx_addr_i(rx_addr_i), .rx_size_i(rx_size_i), .rx_cont_i(rx_cont_i),
    .rx_ack_o(rx_ack_o), .rx_done_o(rx_done_o),
    .tx_req_i(tx_req_i), .tx_addr_i(tx_addr_i), .tx_size_i(tx_size_i), .tx_cont_i(tx_cont_i),
    .tx_ack_o(tx_ack_o), .tx_done_o(tx_done_o),
    .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o),
    .cfg_rwn_o(cfg_rwn_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  logic [37:0] log_q[$];   // completed accesses: {rwn, addr, data (0 for reads)}
  logic [37:0] exp_q[$];
  bit          rd_q[$];    // en bits returned by successive status reads
  int          stall_cur = 0;
  int          hold_err = 0, vcnt = 0, errcnt = 0, exp_err_total = 0;
  bit          exp_err;

  typedef struct {
    bit          tx;
    logic [11:0] addr;
    logic [15:0] size;
    bit          cont;
    int          n1;       // status reads returning en=1 before the first en=0
    int          stall;    // ready-low cycles per access
    int          exp_lat;  // ack-to-done cycles (unused for size 0)
  } vec_t;
  vec_t vt[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [44:0] all_outs();
    return {rx_ack_o, rx_done_o, tx_ack_o, tx_done_o, cfg_valid_o, cfg_rwn_o,
            busy_o, err_o, cfg_addr_o, cfg_data_o};
  endfunction

  // Transaction-level reference: expected access list, error flag and ack-to-done latency.
  function automatic int model(input bit tx, input logic [11:0] a, input logic [15:0] s,
                               input bit c, input int n1, input int st);
    int r, lat;
    logic [4:0] b;
    b = tx ? 5'h04 : 5'h00;
    exp_q.delete();
    exp_err = 1'b0;
    if (s == 16'd0) return 0;
    exp_q.push_back({1'b0, b,        32'(a)});
    exp_q.push_back({1'b0, b + 5'd1, 32'(s)});
    exp_q.push_back({1'b0, b + 5'd2, 32'h10 | 32'(c)});
    if (c) return 3 + 3 * st;
    r = n1 + 1;
    if (TMO && n1 >= MAXP) r = MAXP;
    for (int i = 0; i < r; i++) exp_q.push_back({1'b1, b + 5'd2, 32'h0});
    lat = 3 + 3 * st + r * (G + st + 1);
    if (TMO && n1 >= MAXP) begin
      exp_q.push_back({1'b0, b + 5'd2, 32'h40});
      exp_err = 1'b1;
      lat += st + 1;
    end
    return lat;
  endfunction

  // Bus responder: stalls each access by stall_cur cycles, logs completions, serves status reads.
  initial begin
    int wcnt;
    bit pv, pr, prw, en;
    logic [4:0]  pa;
    logic [31:0] pd, rnd;
    wcnt = 0; pv = 0; pr = 0; prw = 0; pa = '0; pd = '0;
    cfg_ready_i = 1'b0;
    cfg_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        wcnt = 0; pv = 0; cfg_ready_i = 1'b0;
      end else begin
        if (err_o) errcnt++;
        if (pv && !pr && !(cfg_valid_o && cfg_addr_o == pa && cfg_data_o == pd && cfg_rwn_o == prw))
          hold_err++;
        if (cfg_valid_o) begin
          vcnt++;
          if (wcnt >= stall_cur) begin
            cfg_ready_i = 1'b1;
            wcnt = 0;
            log_q.push_back({cfg_rwn_o, cfg_addr_o, cfg_rwn_o ? 32'h0 : cfg_data_o});
            if (cfg_rwn_o) begin
              en = (rd_q.size() > 0) ? rd_q.pop_front() : 1'b0;
              rnd = $urandom;
              rnd[4] = en;
              cfg_data_i = rnd;
            end
          end else begin
            cfg_ready_i = 1'b0;
            wcnt++;
          end
        end else begin
          cfg_ready_i = 1'b0;
          wcnt = 0;
        end
        pv = cfg_valid_o; pr = cfg_ready_i; pa = cfg_addr_o; pd = cfg_data_o; prw = cfg_rwn_o;
      end
    end
  end

  task automatic issue(input bit tx, input logic [11:0] a, input logic [15:0] s, input bit c,
                       input int n1, input int st);
    rd_q.delete();
    for (int i = 0; i < n1; i++) rd_q.push_back(1'b1);
    rd_q.push_back(1'b0);
    stall_cur = st;
    log_q.delete();
    if (tx) begin tx_req_i = 1'b1; tx_addr_i = a; tx_size_i = s; tx_cont_i = c; end
    else    begin rx_req_i = 1'b1; rx_addr_i = a; rx_size_i = s; rx_cont_i = c; end
  endtask

  // Expects the ack on the first negedge after the request is presented to an idle sequencer.
  task automatic complete(input string tag, input bit tx, input logic [11:0] a, input logic [15:0] s,
                          input bit c, input int n1, input int st, input int exp_lat);
    int k, t_ack, lat, lat_m, v0, nchk;
    bit seen;
    v0 = vcnt;
    lat_m = model(tx, a, s, c, n1, st);
    if (exp_lat < 0) exp_lat = lat_m;
    seen = 0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (tx ? tx_ack_o : rx_ack_o) begin seen = 1; break; end
    end
    check({tag, "_ack_seen"}, 64'(seen), 64'd1);
    if (!seen) begin rx_req_i = 1'b0; tx_req_i = 1'b0; return; end
    check({tag, "_ack_lat"}, 64'(k), 64'd1);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    t_ack = cyc;
    if (tx) tx_req_i = 1'b0; else rx_req_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (tx ? tx_done_o : rx_done_o) begin seen = 1; break; end
      @(negedge clk_i);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (!seen) return;
    lat = cyc - t_ack;
    if (s == 16'd0) begin
      check({tag, "_sz0_lat_le1"}, 64'(lat <= 1), 64'd1);
      check({tag, "_sz0_no_valid"}, 64'(vcnt - v0), 64'd0);
    end else begin
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    end
    check({tag, "_err"}, 64'(err_o), 64'(exp_err));
    exp_err_total += int'(exp_err);
    check({tag, "_ntxn"}, 64'(log_q.size()), 64'(exp_q.size()));
    nchk = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++)
      check($sformatf("%s_txn%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  task automatic run_cmd(input string tag, input bit tx, input logic [11:0] a, input logic [15:0] s,
                         input bit c, input int n1, input int st, input int exp_lat);
    @(negedge clk_i);
    issue(tx, a, s, c, n1, st);
    complete(tag, tx, a, s, c, n1, st, exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t_ack, t_done, who;
    bit seen;

    vt[0] = '{1'b0, 12'h123, 16'h0040, 1'b0, 2, 0, 18};
    vt[1] = '{1'b1, 12'hABC, 16'h05EE, 1'b1, 0, 3, 12};
    vt[2] = '{1'b1, 12'h001, 16'h0000, 1'b0, 0, 0, 0};
    vt[3] = '{1'b0, 12'hFFF, 16'hFFFF, 1'b1, 0, 0, 3};
    vt[4] = '{1'b1, 12'h800, 16'h0001, 1'b0, 0, 1, 12};
    vt[5] = '{1'b0, 12'h055, 16'h1000, 1'b0, 1, 2, 23};

    // Reset values, during and just after reset
    repeat (2) @(negedge clk_i);
    check("reset_outs", 64'(all_outs()), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_outs", 64'(all_outs()), 64'd0);

    // Simultaneous requests from reset: RX first, then strict alternation
    @(negedge clk_i);
    stall_cur = 0; rd_q.delete();
    rx_addr_i = 12'h010; rx_size_i = 16'h0010; rx_cont_i = 1'b1;
    tx_addr_i = 12'h020; tx_size_i = 16'h0020; tx_cont_i = 1'b1;
    rx_req_i = 1'b1; tx_req_i = 1'b1;
    t0 = cyc; t_done = 0;
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_i);
        if (rx_ack_o || tx_ack_o) begin seen = 1; break; end
      end
      check($sformatf("arb%0d_ack_seen", g), 64'(seen), 64'd1);
      who = tx_ack_o ? 1 : 0;
      t_ack = cyc;
      check($sformatf("arb%0d_grant_tx", g), 64'(who), 64'(g % 2));
      check($sformatf("arb%0d_ack_cyc", g), 64'(t_ack), 64'((g == 0) ? t0 + 1 : t_done + 2));
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_i);
        if (who == 1 ? tx_done_o : rx_done_o) begin seen = 1; break; end
      end
      check($sformatf("arb%0d_done_seen", g), 64'(seen), 64'd1);
      t_done = cyc;
      check($sformatf("arb%0d_done_lat", g), 64'(t_done - t_ack), 64'd3);
    end
    rx_req_i = 1'b0; tx_req_i = 1'b0;

    // Vector table
    for (int i = 0; i < 6; i++)
      run_cmd($sformatf("vec%0d", i), vt[i].tx, vt[i].addr, vt[i].size, vt[i].cont,
              vt[i].n1, vt[i].stall, vt[i].exp_lat);
    check("bus_hold_during_stall", 64'(hold_err), 64'd0);

    // Reset while polling, then a request held across reset release
    @(negedge clk_i);
    issue(1'b0, 12'h2A0, 16'h0080, 1'b0, 5, 0);
    @(negedge clk_i);
    check("rstmid_ack", 64'(rx_ack_o), 64'd1);
    rx_req_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("rstmid_pwait", 64'({busy_o, cfg_valid_o}), 64'b10);
    rst_i = 1'b1;
    #1;
    check("rstmid_outs", 64'(all_outs()), 64'd0);
    @(negedge clk_i);
    issue(1'b1, 12'h3C0, 16'h0024, 1'b0, 1, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    complete("rst_post", 1'b1, 12'h3C0, 16'h0024, 1'b0, 1, 0, 13);

`ifdef ETH_FRAME_SEQ_TIMEOUT_EN
    run_cmd("tmo", 1'b0, 12'h010, 16'h0020, 1'b0, 8, 0, 19);
`endif

    // Random commands against the model
    for (int i = 0; i < 30; i++) begin
      bit          tx, c;
      logic [11:0] a;
      logic [15:0] s;
      int          n1, st;
      tx = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      a  = 12'($urandom_range(0, 4095));
      s  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      n1 = $urandom_range(0, 4);
      st = $urandom_range(0, 3);
      run_cmd($sformatf("rnd%0d", i), tx, a, s, c, n1, st, -1);
    end
    check("bus_hold_total", 64'(hold_err), 64'd0);
    @(negedge clk_i);
    check("err_pulses", 64'(errcnt), 64'(exp_err_total));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
